// File: rtl/decoder_a_74138.sv
// ---------------------------------------------------------------------------
// decoder_a_74138
//
// Registered 3-to-8 line decoder/demultiplexer in the style of the 74x138.
// Typical use is as an address or chip-select decoder. The decoded value is
// held in an output register, so the selects seen downstream are glitch-free
// and change only on a rising clock edge.
//
// Ports
//   clk_i       in   1  system clock, rising-edge active
//   rst_i       in   1  synchronous active-high reset (drives yn_o to 8'hFF)
//   select_a_i  in   1  select bit 0 (LSB)
//   select_b_i  in   1  select bit 1
//   select_c_i  in   1  select bit 2 (MSB)
//   g1_en_i     in   1  enable, active-high
//   g2a_en_n_i  in   1  enable, active-low
//   g2b_en_n_i  in   1  enable, active-low
//   yn_o        out  8  decoded outputs, active-low; bit k <-> select value k
//
// Timing: one clock from inputs to yn_o, with no combinational path between
// them. At most one bit of yn_o is ever low.
// ---------------------------------------------------------------------------
module decoder_a_74138 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       select_a_i,
  input  logic       select_b_i,
  input  logic       select_c_i,
  input  logic       g1_en_i,
  input  logic       g2a_en_n_i,
  input  logic       g2b_en_n_i,
  output logic [7:0] yn_o
);

  logic       en;
  logic [2:0] sel;
  logic [7:0] yn_d;
  logic [7:0] yn_q;

  // All three enables must be in their active state at the same time.
  assign en  = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i;
  assign sel = {select_c_i, select_b_i, select_a_i};

  // The all-high default is written first, and a bit is pulled low only
  // under a true enable. When en is 0, the select inputs are never looked
  // at. Unknown selects therefore cannot reach the output while the decoder
  // is disabled.
  always_comb begin
    yn_d = 8'hFF;
    if (en) begin
      for (int k = 0; k < 8; k++) begin
        if (sel == k[2:0]) begin
          yn_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yn_q <= 8'hFF;
    end else begin
      yn_q <= yn_d;
    end
  end

  assign yn_o = yn_q;

endmodule

// File: tb/tb_decoder_a_74138.sv
// ---------------------------------------------------------------------------
// tb_decoder_a_74138
//
// Self-checking bench for the registered 74x138-style decoder.
//
// The driver applies one input combination per clock. Right after the
// sampling edge, it pushes the value that the reference model predicts for
// that edge onto a scoreboard queue.
//
// The monitor runs on the falling edge. It pops one expectation per cycle
// and compares it with yn_o. It also checks that no more than one bit of
// yn_o is low.
// ---------------------------------------------------------------------------
module tb_decoder_a_74138;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       select_a_i;
  logic       select_b_i;
  logic       select_c_i;
  logic       g1_en_i;
  logic       g2a_en_n_i;
  logic       g2b_en_n_i;
  logic [7:0] yn_o;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  typedef struct {
    int         id;
    logic       rst;
    logic [2:0] enables;  // {g1, g2a_n, g2b_n}
    logic [2:0] sel;
    logic [7:0] exp;
  } txn_t;

  txn_t sb_q[$];

  decoder_a_74138 dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .select_a_i (select_a_i),
    .select_b_i (select_b_i),
    .select_c_i (select_c_i),
    .g1_en_i    (g1_en_i),
    .g2a_en_n_i (g2a_en_n_i),
    .g2b_en_n_i (g2b_en_n_i),
    .yn_o       (yn_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model, written as plain arithmetic.
  // Reset or any inactive enable gives all-high (255).
  // Otherwise the output is 255 with the weight 2**sel removed.
  function automatic logic [7:0] model(input logic rst, input logic g1,
                                       input logic g2a_n, input logic g2b_n,
                                       input logic [2:0] sel);
    int v;
    if (rst === 1'b1) begin
      v = 255;
    end else if (g1 === 1'b1 && g2a_n === 1'b0 && g2b_n === 1'b0) begin
      v = 255 - (1 << int'(sel));
    end else begin
      v = 255;
    end
    return 8'(v);
  endfunction

  // One cycle of stimulus.
  // When sel_x is set, the select inputs are driven to X.
  task automatic drive(input logic rst, input logic g1, input logic g2a_n,
                       input logic g2b_n, input logic [2:0] sel,
                       input bit sel_x);
    txn_t t;
    @(negedge clk_i);
    #1;
    rst_i      = rst;
    g1_en_i    = g1;
    g2a_en_n_i = g2a_n;
    g2b_en_n_i = g2b_n;
    if (sel_x) begin
      {select_c_i, select_b_i, select_a_i} = 3'bxxx;
    end else begin
      {select_c_i, select_b_i, select_a_i} = sel;
    end
    @(posedge clk_i);
    #1;
    t.id      = txn_id;
    t.rst     = rst;
    t.enables = {g1, g2a_n, g2b_n};
    t.sel     = sel;
    t.exp     = model(rst, g1, g2a_n, g2b_n, sel);
    sb_q.push_back(t);
    txn_id++;
  endtask

  // Monitor: one comparison per queued transaction, plus the invariant check.
  initial begin
    txn_t t;
    int   zeros;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        t = sb_q.pop_front();

        checks++;
        if (yn_o !== t.exp) begin
          errors++;
          $display("FAIL yn_o txn %0d rst=%b en=%b sel=%0d got %h expected %h",
                   t.id, t.rst, t.enables, t.sel, yn_o, t.exp);
        end else begin
          $display("txn %0d rst=%b en=%b sel=%0d yn_o=%h ok",
                   t.id, t.rst, t.enables, t.sel, yn_o);
        end

        zeros = 8 - $countones(yn_o);
        checks++;
        if (zeros > 1) begin
          errors++;
          $display("FAIL one_low txn %0d got %0d low bits (yn_o=%h) expected at most 1",
                   t.id, zeros, yn_o);
        end
      end
    end
  end

  initial begin
    logic r, g1, g2a, g2b;
    logic [2:0] s;

    rst_i      = 1'b1;
    g1_en_i    = 1'bx;
    g2a_en_n_i = 1'bx;
    g2b_en_n_i = 1'bx;
    {select_c_i, select_b_i, select_a_i} = 3'bxxx;

    // Reset for two cycles, with enables and selects all unknown.
    drive(1'b1, 1'bx, 1'bx, 1'bx, 3'd0, 1'b1);
    drive(1'b1, 1'bx, 1'bx, 1'bx, 3'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1);

    // G1 low: every combination of the active-low enables stays disabled.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);

    // G1 high: either active-low enable being high still disables.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

    // Enabled select sweep 0..7, then back to 0.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 3'(i), 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

    // Disable in the middle of operation, then re-enable.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0);

    // Reset in the middle of operation.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);

    // Random traffic. The bias favours the enabled state, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      r   = ($urandom_range(15) == 0);
      g1  = ($urandom_range(3) != 0);
      g2a = ($urandom_range(3) == 0);
      g2b = ($urandom_range(3) == 0);
      s   = 3'($urandom_range(7));
      drive(r, g1, g2a, g2b, s, 1'b0);
    end

    // Let the monitor drain. The wait is bounded.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
      @(negedge clk_i);
      #1;
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
